sram_bank_ctrl: RTL and testbench
=================================

Name: sram_bank_ctrl

Overview:
- Parametrised SRAM bank controller for the vector cache data array.
- Wraps one mem_model row of LANES x WORD_W bits.
- Serves three request types:
  - single-word normal reads/writes, in contiguous-word mode or strided byte-gather mode;
  - multi-beat evict reads, where one request streams the whole row out;
  - multi-beat linefill writes, where beats are staged and the full row is committed in one write.
- Adds valid/ready handshakes, write-over-read arbitration, an internal burst beat counter and an optional output register.

Parameters:
ADDR_W, 9, SRAM row address width (depth = 2**ADDR_W)
LANES, 4, words per SRAM row; power of two, >= 2
WORD_W, 32, word width in bits; multiple of 8
OUT_REG, 0, 1 adds an output register stage on rd_data* (read latency +1)
SEL_W, $clog2(LANES), derived, not overridable
Elaboration check: byte-gather mode requires LANES*8 == WORD_W. If this does not hold, an rd_mode/wr_mode of 1 is treated as mode 0.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_req_vld  in  1  write request valid
wr_req_rdy  out  1  write request ready; 1 whenever out of reset
wr_addr  in  ADDR_W  write row address
wr_sel  in  SEL_W  word index (mode 0) or byte index (mode 1)
wr_mode  in  1  0 = contiguous word; 1 = byte-gather
wr_fill  in  1  1 = linefill beat
wr_data  in  WORD_W  write data
rd_req_vld  in  1  read request valid
rd_req_rdy  out  1  read request ready
rd_addr  in  ADDR_W  read row address
rd_sel  in  SEL_W  word/byte index
rd_mode  in  1  0 = contiguous word; 1 = byte-gather
rd_burst  in  1  1 = evict read of the full row
rd_data_vld  out  1  read data valid; no backpressure
rd_data  out  WORD_W  read data
rd_data_beat  out  SEL_W  beat index (sel for single reads)
rd_data_last  out  1  last beat of a response (1 for single reads)
fill_busy  out  1  linefill in progress
fill_err  out  1  one-cycle pulse: fill beat dropped

Behaviour:
Reset
- Asynchronous, active-low. All outputs reset to 0 except wr_req_rdy, which is 0 only while rst_n is low.
- rd_req_rdy becomes 1 on the first cycle after reset release.
- Reset mid-burst or mid-fill discards the beat counters, staging buffer and pipeline. SRAM contents are not reset.

Arbitration
- An accepted write (wr_req_vld & wr_req_rdy) owns the SRAM that cycle.
- rd_req_rdy = !evict_busy & !wr_req_vld.
- Reads are never accepted in the same cycle as a write.

Normal write (wr_fill = 0)
- Mode 0: byte enables and data placed on word wr_sel.
- Mode 1: byte k of wr_data goes to byte wr_sel of word k, for k = 0..LANES-1.
- Written in the accept cycle.

Linefill (wr_fill = 1)
- Beat 0 latches the row address, sets fill_busy and stores into staging lane 0.
- Beat n (n = 1..LANES-2) stores into staging lane n.
- Beat LANES-1 performs one full-row write (all byte enables) of {wr_data, staging} in its accept cycle, then clears fill_busy.
- The beat index comes from the internal counter; wr_sel and wr_mode are ignored for fill beats.
- A fill beat whose wr_addr differs from the latched address is dropped: fill_err pulses and the counter holds.
- Normal writes interleaved during a fill are allowed. They do not disturb staging, but a same-row normal write is overwritten by the final fill commit.

Normal read (rd_burst = 0)
- Accepted at cycle T; SRAM read at T.
- rd_data_vld = 1 at T+1+OUT_REG, with rd_data_last = 1 and rd_data_beat = rd_sel.
- Mode 0 returns word rd_sel.
- Mode 1 returns {byte rd_sel of word LANES-1, ..., byte rd_sel of word 0}.
- Mode and sel are registered alongside the request.
- Back-to-back reads give one response per cycle.

Evict read (rd_burst = 1)
- Accepted at cycle T; the full row is latched into the evict buffer at T+1.
- Beats 0..LANES-1 (word order) appear on consecutive cycles T+1+OUT_REG .. T+LANES+OUT_REG.
- rd_data_last = 1 on beat LANES-1.
- evict_busy holds rd_req_rdy low for cycles T+1..T+LANES-1, so a read accepted at T+LANES responds contiguously after the last beat.
- Writes remain accepted during evict_busy, because the buffer isolates the row; a write at T+1 or later does not alter beats in flight.

Hazards
- A read accepted after a write completes returns the written data.
- A same-cycle read and write cannot occur.

Test Plan:
- Mode-0 write addr 5, sel 2, data 0xDEADBEEF; read addr 5, sel 2 one cycle later -> rd_data_vld at T+1, rd_data 0xDEADBEEF, rd_data_last 1, other words unchanged.
- Write mode 0 words 0..3 of addr 7 = 0x03020100, 0x13121110, 0x23222120, 0x33323130; read mode 1 sel 1 -> rd_data 0x31211101. Write mode 1 sel 3 data 0xAABBCCDD, then read word 2 -> 0xBB222120.
- Linefill addr 9 with beats 0x11,0x22,0x33,0x44 across cycles, with a normal write to addr 3 inserted between beats 1 and 2 -> fill_busy high until beat 3; evict read addr 9 returns beats 0x11,0x22,0x33,0x44 on 4 consecutive cycles, rd_data_last only on the 4th; addr 3 data intact.
- Fill beat 0 at addr 9, then beat with addr 10 -> fill_err pulses once, counter holds; the next beats at addr 9 complete the fill with the correct lanes.
- Evict read addr 9 plus rd_req_vld held high -> rd_req_rdy low for 3 cycles, next read accepted at T+4, its data at T+5 directly after last beat. Write to addr 9 during the burst does not change beats. Repeat with OUT_REG=1 -> every response delayed exactly 1 cycle.
- Assert rst_n low mid-burst (beat 1) -> rd_data_vld drops to 0 immediately, fill_busy 0; after release rd_req_rdy 1, SRAM data from before reset reads back unchanged.

Source files
------------

// File: rtl/sram_bank_ctrl.sv
// SRAM bank controller for the vector cache data array: word/byte-gather single access,
// staged linefill writes, buffered evict bursts, and write-over-read arbitration.
module sram_bank_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int LANES   = 4,
    parameter int WORD_W  = 32,
    parameter int OUT_REG = 0,
    localparam int SEL_W  = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req_vld,
    output logic              wr_req_rdy,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic              wr_mode,
    input  logic              wr_fill,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_req_vld,
    output logic              rd_req_rdy,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [SEL_W-1:0]  rd_sel,
    input  logic              rd_mode,
    input  logic              rd_burst,
    output logic              rd_data_vld,
    output logic [WORD_W-1:0] rd_data,
    output logic [SEL_W-1:0]  rd_data_beat,
    output logic              rd_data_last,
    output logic              fill_busy,
    output logic              fill_err
);
    localparam int BPW   = WORD_W / 8;
    localparam int ROW_W = LANES * WORD_W;
    localparam int ROW_B = LANES * BPW;
    localparam bit GATHER_OK = (LANES * 8 == WORD_W);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);

    logic [ROW_W-1:0]  r_mem [2**ADDR_W];
    logic [WORD_W-1:0] r_stage [LANES-1];
    logic              r_fill_busy;
    logic [SEL_W-1:0]  r_fill_cnt;
    logic [ADDR_W-1:0] r_fill_addr;
    logic              r_fill_err;
    logic              r_rd_en;
    logic              r_sgl_vld_p0;
    logic              r_mode_p0;
    logic [SEL_W-1:0]  r_sel_p0;
    logic [ROW_W-1:0]  r_row_p0;
    logic              r_ev_act;
    logic [SEL_W-1:0]  r_ev_beat;

    logic                     w_wr_acc;
    logic                     w_fill_acc;
    logic                     w_fill_drop;
    logic                     w_fill_commit;
    logic                     w_we;
    logic [ROW_W-1:0]         w_we_data;
    logic [ROW_B-1:0]         w_we_be;
    logic [(LANES-1)*WORD_W-1:0] w_stage_row;
    logic                     w_ev_busy;
    logic                     w_rd_acc;
    logic [WORD_W-1:0]        w_gather;
    logic                     w_out_vld;
    logic [WORD_W-1:0]        w_out_data;
    logic [SEL_W-1:0]         w_out_beat;
    logic                     w_out_last;

    assign wr_req_rdy = rst_n;
    assign w_ev_busy  = r_ev_act & (r_ev_beat != LAST);
    assign rd_req_rdy = r_rd_en & !w_ev_busy & !wr_req_vld;
    assign w_rd_acc   = rd_req_vld & rd_req_rdy;
    assign fill_busy  = r_fill_busy;
    assign fill_err   = r_fill_err;

    // Write side: decide which bytes of the row are written this cycle
    always_comb begin
        w_wr_acc      = wr_req_vld & wr_req_rdy;
        w_fill_acc    = w_wr_acc & wr_fill;
        w_fill_drop   = w_fill_acc & r_fill_busy & (wr_addr != r_fill_addr);
        w_fill_commit = w_fill_acc & r_fill_busy & !w_fill_drop & (r_fill_cnt == LAST);
        w_we          = 1'b0;
        w_we_data     = '0;
        w_we_be       = '0;
        w_stage_row   = '0;
        for (int i = 0; i < LANES - 1; i++) begin
            w_stage_row[i*WORD_W +: WORD_W] = r_stage[i];
        end
        if (w_fill_commit) begin
            w_we      = 1'b1;
            w_we_data = {wr_data, w_stage_row};
            w_we_be   = '1;
        end else if (w_wr_acc && !wr_fill) begin
            w_we = 1'b1;
            if (wr_mode && GATHER_OK) begin
                for (int k = 0; k < LANES; k++) begin
                    w_we_data[k*WORD_W +: WORD_W] = {BPW{wr_data[k*8 +: 8]}};
                    w_we_be[k*BPW + int'(wr_sel)] = 1'b1;
                end
            end else begin
                for (int k = 0; k < LANES; k++) begin
                    w_we_data[k*WORD_W +: WORD_W] = wr_data;
                end
                w_we_be[int'(wr_sel)*BPW +: BPW] = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < ROW_B; b++) begin
            if (w_we && w_we_be[b]) begin
                r_mem[wr_addr][b*8 +: 8] <= w_we_data[b*8 +: 8];
            end
        end
        if (w_rd_acc) begin
            r_row_p0 <= r_mem[rd_addr];
        end
        if (w_fill_acc && !w_fill_drop && !w_fill_commit) begin
            r_stage[r_fill_busy ? r_fill_cnt : '0] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_busy <= 1'b0;
            r_fill_cnt  <= '0;
            r_fill_addr <= '0;
            r_fill_err  <= 1'b0;
        end else begin
            r_fill_err <= w_fill_drop;
            if (w_fill_acc && !w_fill_drop) begin
                if (!r_fill_busy) begin
                    r_fill_busy <= 1'b1;
                    r_fill_addr <= wr_addr;
                    r_fill_cnt  <= SEL_W'(1);
                end else if (w_fill_commit) begin
                    r_fill_busy <= 1'b0;
                    r_fill_cnt  <= '0;
                end else begin
                    r_fill_cnt <= r_fill_cnt + SEL_W'(1);
                end
            end
        end
    end

    // Stage p0: row captured at accept; it doubles as the evict buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_en      <= 1'b0;
            r_sgl_vld_p0 <= 1'b0;
            r_mode_p0    <= 1'b0;
            r_sel_p0     <= '0;
            r_ev_act     <= 1'b0;
            r_ev_beat    <= '0;
        end else begin
            r_rd_en      <= 1'b1;
            r_sgl_vld_p0 <= w_rd_acc & !rd_burst;
            if (w_rd_acc) begin
                r_mode_p0 <= rd_mode & GATHER_OK;
                r_sel_p0  <= rd_sel;
            end
            if (w_rd_acc && rd_burst) begin
                r_ev_act  <= 1'b1;
                r_ev_beat <= '0;
            end else if (r_ev_act) begin
                if (r_ev_beat == LAST) begin
                    r_ev_act <= 1'b0;
                end else begin
                    r_ev_beat <= r_ev_beat + SEL_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_gather = '0;
        if (GATHER_OK) begin
            for (int k = 0; k < LANES; k++) begin
                w_gather[k*8 +: 8] = r_row_p0[k*WORD_W + int'(r_sel_p0)*8 +: 8];
            end
        end
        w_out_vld  = r_sgl_vld_p0 | r_ev_act;
        w_out_beat = r_ev_act ? r_ev_beat : r_sel_p0;
        w_out_last = r_ev_act ? (r_ev_beat == LAST) : 1'b1;
        if (r_ev_act) begin
            w_out_data = r_row_p0[int'(r_ev_beat)*WORD_W +: WORD_W];
        end else if (r_mode_p0) begin
            w_out_data = w_gather;
        end else begin
            w_out_data = r_row_p0[int'(r_sel_p0)*WORD_W +: WORD_W];
        end
        if (!w_out_vld) begin
            w_out_data = '0;
            w_out_beat = '0;
            w_out_last = 1'b0;
        end
    end

    // Stage p1: optional output register
    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              r_vld_p1;
            logic              r_last_p1;
            logic [SEL_W-1:0]  r_beat_p1;
            logic [WORD_W-1:0] r_data_p1;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_vld_p1 <= 1'b0;
                else        r_vld_p1 <= w_out_vld;
            end
            always_ff @(posedge clk) begin
                r_data_p1 <= w_out_data;
                r_beat_p1 <= w_out_beat;
                r_last_p1 <= w_out_last;
            end
            assign rd_data_vld  = r_vld_p1;
            assign rd_data      = r_vld_p1 ? r_data_p1 : '0;
            assign rd_data_beat = r_vld_p1 ? r_beat_p1 : '0;
            assign rd_data_last = r_vld_p1 & r_last_p1;
        end else begin : g_comb
            assign rd_data_vld  = w_out_vld;
            assign rd_data      = w_out_data;
            assign rd_data_beat = w_out_beat;
            assign rd_data_last = w_out_last;
        end
    endgenerate
endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Bench for sram_bank_ctrl: two instances (OUT_REG 0 and 1) share stimulus; each
// read response is queued on acceptance and compared when the DUT presents it.
module tb_sram_bank_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        wr_req_vld = 0, wr_mode = 0, wr_fill = 0;
    logic [8:0]  wr_addr = '0, rd_addr = '0;
    logic [1:0]  wr_sel = '0, rd_sel = '0;
    logic [31:0] wr_data = '0;
    logic        rd_req_vld = 0, rd_mode = 0, rd_burst = 0;

    logic        wr_req_rdy_0, rd_req_rdy_0, rd_data_vld_0, rd_data_last_0, fill_busy_0, fill_err_0;
    logic        wr_req_rdy_1, rd_req_rdy_1, rd_data_vld_1, rd_data_last_1, fill_busy_1, fill_err_1;
    logic [31:0] rd_data_0, rd_data_1;
    logic [1:0]  rd_data_beat_0, rd_data_beat_1;

    sram_bank_ctrl #(.ADDR_W(9), .LANES(4), .WORD_W(32), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy_0), .wr_addr(wr_addr), .wr_sel(wr_sel),
        .wr_mode(wr_mode), .wr_fill(wr_fill), .wr_data(wr_data),
        .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy_0), .rd_addr(rd_addr), .rd_sel(rd_sel),
        .rd_mode(rd_mode), .rd_burst(rd_burst),
        .rd_data_vld(rd_data_vld_0), .rd_data(rd_data_0), .rd_data_beat(rd_data_beat_0),
        .rd_data_last(rd_data_last_0), .fill_busy(fill_busy_0), .fill_err(fill_err_0));

    sram_bank_ctrl #(.ADDR_W(9), .LANES(4), .WORD_W(32), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy_1), .wr_addr(wr_addr), .wr_sel(wr_sel),
        .wr_mode(wr_mode), .wr_fill(wr_fill), .wr_data(wr_data),
        .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy_1), .rd_addr(rd_addr), .rd_sel(rd_sel),
        .rd_mode(rd_mode), .rd_burst(rd_burst),
        .rd_data_vld(rd_data_vld_1), .rd_data(rd_data_1), .rd_data_beat(rd_data_beat_1),
        .rd_data_last(rd_data_last_1), .fill_busy(fill_busy_1), .fill_err(fill_err_1));

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [1:0]  beat;
        logic        last;
    } exp_t;

    typedef struct {
        bit          is_rd;
        logic [8:0]  addr;
        logic [1:0]  sel;
        logic        mode;
        logic [31:0] val;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input logic vld, input logic [31:0] d,
                       input logic [1:0] b, input logic l);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (id == 0 && q0.size() > 0 && q0[0].due <= cyc) begin e = q0.pop_front(); have = 1'b1; end
        if (id == 1 && q1.size() > 0 && q1[0].due <= cyc) begin e = q1.pop_front(); have = 1'b1; end
        if (have) begin
            chk($sformatf("rd_due_r%0d", id), cyc, e.due);
            chk($sformatf("rd_vld_r%0d", id), vld, 1'b1);
            chk($sformatf("rd_data_r%0d", id), d, e.data);
            chk($sformatf("rd_beat_r%0d", id), b, e.beat);
            chk($sformatf("rd_last_r%0d", id), l, e.last);
        end else begin
            chk($sformatf("rd_idle_r%0d", id), vld, 1'b0);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        mon(0, rd_data_vld_0, rd_data_0, rd_data_beat_0, rd_data_last_0);
        mon(1, rd_data_vld_1, rd_data_1, rd_data_beat_1, rd_data_last_1);
    end

    task automatic nxt();
        @(negedge clk);
        wr_req_vld = 1'b0;
        wr_fill    = 1'b0;
        rd_req_vld = 1'b0;
        rd_burst   = 1'b0;
    endtask

    task automatic set_wr(input logic [8:0] a, input logic [1:0] s, input logic m,
                          input logic f, input logic [31:0] d);
        wr_req_vld = 1'b1; wr_addr = a; wr_sel = s; wr_mode = m; wr_fill = f; wr_data = d;
    endtask

    task automatic set_rd(input logic [8:0] a, input logic [1:0] s, input logic m, input logic b);
        rd_req_vld = 1'b1; rd_addr = a; rd_sel = s; rd_mode = m; rd_burst = b;
    endtask

    task automatic expect_rd(input int a, input logic [31:0] d, input logic [1:0] b, input logic l);
        q0.push_back('{due: a, data: d, beat: b, last: l});
        q1.push_back('{due: a + 1, data: d, beat: b, last: l});
    endtask

    task automatic rd1(input logic [8:0] a, input logic [1:0] s, input logic m, input logic [31:0] d);
        set_rd(a, s, m, 1'b0);
        expect_rd(cyc + 1, d, s, 1'b1);
    endtask

    task automatic rdev(input logic [8:0] a, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
        set_rd(a, 2'd0, 1'b0, 1'b1);
        expect_rd(cyc + 1, d0, 2'd0, 1'b0);
        expect_rd(cyc + 2, d1, 2'd1, 1'b0);
        expect_rd(cyc + 3, d2, 2'd2, 1'b0);
        expect_rd(cyc + 4, d3, 2'd3, 1'b1);
    endtask

    task automatic chk_rdy(input string nm, input logic exp);
        chk({nm, "_r0"}, rd_req_rdy_0, exp);
        chk({nm, "_r1"}, rd_req_rdy_1, exp);
    endtask

    task automatic chk_fill(input string nm, input logic busy, input logic err);
        chk({nm, "_busy_r0"}, fill_busy_0, busy);
        chk({nm, "_busy_r1"}, fill_busy_1, busy);
        chk({nm, "_err_r0"}, fill_err_0, err);
        chk({nm, "_err_r1"}, fill_err_1, err);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_wr_rdy"}, {wr_req_rdy_0, wr_req_rdy_1}, 2'b00);
        chk_rdy({nm, "_rd_rdy"}, 1'b0);
        chk({nm, "_vld"}, {rd_data_vld_0, rd_data_vld_1}, 2'b00);
        chk({nm, "_data0"}, rd_data_0, 32'h0);
        chk({nm, "_data1"}, rd_data_1, 32'h0);
        chk({nm, "_beat_last"}, {rd_data_beat_0, rd_data_last_0, rd_data_beat_1, rd_data_last_1}, 6'h0);
        chk_fill(nm, 1'b0, 1'b0);
    endtask

    initial begin
        tbl.push_back('{1'b0, 9'd5, 2'd0, 1'b0, 32'h50505050});
        tbl.push_back('{1'b0, 9'd5, 2'd1, 1'b0, 32'h51515151});
        tbl.push_back('{1'b0, 9'd5, 2'd3, 1'b0, 32'h53535353});
        tbl.push_back('{1'b0, 9'd5, 2'd2, 1'b0, 32'hDEADBEEF});
        tbl.push_back('{1'b1, 9'd5, 2'd2, 1'b0, 32'hDEADBEEF});
        tbl.push_back('{1'b1, 9'd5, 2'd0, 1'b0, 32'h50505050});
        tbl.push_back('{1'b1, 9'd5, 2'd1, 1'b0, 32'h51515151});
        tbl.push_back('{1'b1, 9'd5, 2'd3, 1'b0, 32'h53535353});
        tbl.push_back('{1'b0, 9'd7, 2'd0, 1'b0, 32'h03020100});
        tbl.push_back('{1'b0, 9'd7, 2'd1, 1'b0, 32'h13121110});
        tbl.push_back('{1'b0, 9'd7, 2'd2, 1'b0, 32'h23222120});
        tbl.push_back('{1'b0, 9'd7, 2'd3, 1'b0, 32'h33323130});
        tbl.push_back('{1'b1, 9'd7, 2'd1, 1'b1, 32'h31211101});
        tbl.push_back('{1'b1, 9'd7, 2'd0, 1'b1, 32'h30201000});
        tbl.push_back('{1'b1, 9'd7, 2'd3, 1'b1, 32'h33231303});
        tbl.push_back('{1'b0, 9'd7, 2'd3, 1'b1, 32'hAABBCCDD});
        tbl.push_back('{1'b1, 9'd7, 2'd2, 1'b0, 32'hBB222120});
        tbl.push_back('{1'b1, 9'd7, 2'd0, 1'b0, 32'hDD020100});
        tbl.push_back('{1'b1, 9'd7, 2'd3, 1'b0, 32'hAA323130});
        tbl.push_back('{1'b1, 9'd7, 2'd1, 1'b0, 32'hCC121110});

        repeat (2) @(negedge clk);
        #1 chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_wr_rdy", {wr_req_rdy_0, wr_req_rdy_1}, 2'b11);
        nxt();
        #1 chk_rdy("rel_rd_rdy", 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            nxt();
            if (tbl[i].is_rd) rd1(tbl[i].addr, tbl[i].sel, tbl[i].mode, tbl[i].val);
            else set_wr(tbl[i].addr, tbl[i].sel, tbl[i].mode, 1'b0, tbl[i].val);
            #1 chk_rdy($sformatf("tbl%0d_rdy", i), tbl[i].is_rd);
        end

        // write and read offered together: write wins, read retried next cycle
        nxt(); set_wr(9'd5, 2'd1, 1'b0, 1'b0, 32'h12345678); set_rd(9'd5, 2'd1, 1'b0, 1'b0);
        #1 chk_rdy("wr_over_rd", 1'b0);
        nxt(); rd1(9'd5, 2'd1, 1'b0, 32'h12345678);
        #1 chk_rdy("rd_retry", 1'b1);

        // linefill row 9 with an interleaved normal write to row 3
        nxt(); set_wr(9'd9, 2'd2, 1'b0, 1'b1, 32'h11); #1 chk_fill("lf0", 1'b0, 1'b0);
        nxt(); set_wr(9'd9, 2'd0, 1'b0, 1'b1, 32'h22); #1 chk_fill("lf1", 1'b1, 1'b0);
        nxt(); set_wr(9'd3, 2'd0, 1'b0, 1'b0, 32'h3333AAAA); #1 chk_fill("lfn", 1'b1, 1'b0);
        nxt(); set_wr(9'd9, 2'd3, 1'b1, 1'b1, 32'h33); #1 chk_fill("lf2", 1'b1, 1'b0);
        nxt(); set_wr(9'd9, 2'd1, 1'b0, 1'b1, 32'h44); #1 chk_fill("lf3", 1'b1, 1'b0);
        nxt(); rdev(9'd9, 32'h11, 32'h22, 32'h33, 32'h44); #1 chk_fill("lf_done", 1'b0, 1'b0);
        repeat (4) nxt();
        rd1(9'd3, 2'd0, 1'b0, 32'h3333AAAA);

        // dropped beat at a foreign address
        nxt(); set_wr(9'd9, 2'd0, 1'b0, 1'b1, 32'hA0); #1 chk_fill("fe0", 1'b0, 1'b0);
        nxt(); set_wr(9'd10, 2'd0, 1'b0, 1'b1, 32'hEE); #1 chk_fill("fe_bad", 1'b1, 1'b0);
        nxt(); set_wr(9'd9, 2'd0, 1'b0, 1'b1, 32'hA1); #1 chk_fill("fe_pulse", 1'b1, 1'b1);
        nxt(); set_wr(9'd9, 2'd0, 1'b0, 1'b1, 32'hA2); #1 chk_fill("fe_clear", 1'b1, 1'b0);
        nxt(); set_wr(9'd9, 2'd0, 1'b0, 1'b1, 32'hA3); #1 chk_fill("fe3", 1'b1, 1'b0);
        nxt(); #1 chk_fill("fe_done", 1'b0, 1'b0);

        // evict with a read held pending and a write landing mid-burst
        nxt(); rdev(9'd9, 32'hA0, 32'hA1, 32'hA2, 32'hA3); #1 chk_rdy("ev_acc", 1'b1);
        nxt(); set_rd(9'd9, 2'd0, 1'b0, 1'b0); set_wr(9'd9, 2'd0, 1'b0, 1'b0, 32'hFFFFFFFF);
        #1 chk_rdy("ev_busy1", 1'b0);
        nxt(); set_rd(9'd9, 2'd0, 1'b0, 1'b0); #1 chk_rdy("ev_busy2", 1'b0);
        nxt(); set_rd(9'd9, 2'd0, 1'b0, 1'b0); #1 chk_rdy("ev_busy3", 1'b0);
        nxt(); rd1(9'd9, 2'd0, 1'b0, 32'hFFFFFFFF); #1 chk_rdy("ev_next", 1'b1);

        // reset while an evict burst and a linefill are in flight
        nxt(); set_wr(9'd20, 2'd0, 1'b0, 1'b1, 32'hC0);
        nxt(); rdev(9'd7, 32'hDD020100, 32'hCC121110, 32'hBB222120, 32'hAA323130);
        #1 chk_fill("pre_rst", 1'b1, 1'b0);
        nxt();
        nxt();
        q0.delete();
        q1.delete();
        rst_n = 1'b0;
        #1 chk_reset("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nxt(); #1 chk_rdy("post_rst_rdy", 1'b1);
        chk_fill("post_rst", 1'b0, 1'b0);
        rd1(9'd7, 2'd0, 1'b0, 32'hDD020100);
        nxt(); rd1(9'd7, 2'd1, 1'b0, 32'hCC121110);
        nxt(); rd1(9'd7, 2'd2, 1'b0, 32'hBB222120);
        nxt(); rd1(9'd7, 2'd3, 1'b0, 32'hAA323130);
        nxt(); rd1(9'd5, 2'd2, 1'b0, 32'hDEADBEEF);
        nxt(); rd1(9'd3, 2'd0, 1'b0, 32'h3333AAAA);

        repeat (6) nxt();
        chk("sb_drain_r0", q0.size(), 0);
        chk("sb_drain_r1", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
